// File: rtl/ovc_pkg.sv
// Shared types for the overclock stress checker: FSM state encoding and the
// 24-bit PRBS polynomial (x^24+x^23+x^22+x^17+1).
package ovc_pkg;

   localparam int LFSR_W = 24;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOCK_WAIT = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_DONE      = 3'd5,
      ST_FAIL      = 3'd6
   } ovc_state_t;

   // Fibonacci step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ovc_prbs_lfsr.sv
// PRBS word source; one instance drives the pipeline, a second regenerates
// the expected sequence at the pipeline output.
module ovc_prbs_lfsr
   import ovc_pkg::*;
#(
   parameter int                DATA_W = 24,
   parameter logic [LFSR_W-1:0] SEED   = 24'h000001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   output logic [DATA_W-1:0] word
);

   logic [LFSR_W-1:0] state_r;

   // Reseed on reset or load, otherwise advance once per enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= SEED;
      end else if (load) begin
         state_r <= seed;
      end else if (en) begin
         state_r <= lfsr_step(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign word = state_r[DATA_W-1:0];

endmodule

// File: rtl/overclock_stress_checker.sv
// PLL-qualified PRBS pipeline timing-margin tester. Defining OVC_MAC_STRESS_EN
// adds two redundant registered multipliers at the pipeline output.
module overclock_stress_checker
   import ovc_pkg::*;
#(
   parameter int                DATA_W        = 24,
   parameter int                PIPE_STAGES   = 4,
   parameter int                SETTLE_CYCLES = 1024,
   parameter int                RUN_CYCLES    = 1048576,
   parameter int                ERR_W         = 16,
   parameter logic [LFSR_W-1:0] SEED          = 24'h000001
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             start,
   input  logic             inject_err,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             lock_lost,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   ovc_state_t        state_r;
   logic [31:0]       cnt_r;
   logic              busy_r, done_r, pass_r, lock_lost_r;
   logic [ERR_W-1:0]  err_cnt_r, err_nxt_s;
   logic              lock_meta_r, lock_sync_r;
   logic [DATA_W-1:0] pipe_data_r [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] pipe_valid_r;
   logic [DATA_W-1:0] gen_word_s, chk_word_s, pipe_out_s;
   logic              run_s, start_ok_s, out_valid_s, err_inc_s;

   assign run_s       = (state_r == ST_RUN);
   assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_FAIL));
   assign pipe_out_s  = pipe_data_r[PIPE_STAGES-1];
   assign out_valid_s = pipe_valid_r[PIPE_STAGES-1] && ((state_r == ST_RUN) || (state_r == ST_DRAIN));

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= pll_locked;
         lock_sync_r <= lock_meta_r;
      end
   end

   ovc_prbs_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_gen (
      .clk(clk), .rst_n(rst_n), .en(run_s), .load(start_ok_s), .seed(SEED), .word(gen_word_s)
   );

   ovc_prbs_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_chk (
      .clk(clk), .rst_n(rst_n), .en(out_valid_s), .load(start_ok_s), .seed(SEED), .word(chk_word_s)
   );

   // Data pipeline; an injected error flips the LSB of the word entering stage 0.
   always_ff @(posedge clk) begin
      if (!rst_n || start_ok_s) begin
         pipe_valid_r <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) pipe_data_r[i] <= '0;
      end else begin
         pipe_valid_r[0] <= run_s;
         pipe_data_r[0]  <= gen_word_s ^ DATA_W'(inject_err && run_s);
         for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_valid_r[i] <= pipe_valid_r[i-1];
            pipe_data_r[i]  <= pipe_data_r[i-1];
         end
      end
   end

`ifdef OVC_MAC_STRESS_EN
   logic [DATA_W-1:0]   mac_prev_r;
   logic [2*DATA_W-1:0] prod_a_r, prod_b_r;
   logic                mac_valid_r;

   // Redundant multiply paths; any disagreement means a timing failure.
   always_ff @(posedge clk) begin
      if (!rst_n || start_ok_s) begin
         mac_prev_r  <= '0;
         prod_a_r    <= '0;
         prod_b_r    <= '0;
         mac_valid_r <= 1'b0;
      end else begin
         mac_prev_r  <= out_valid_s ? pipe_out_s : mac_prev_r;
         prod_a_r    <= pipe_out_s * mac_prev_r;
         prod_b_r    <= pipe_out_s * mac_prev_r;
         mac_valid_r <= out_valid_s;
      end
   end

   assign err_inc_s = (out_valid_s && (pipe_out_s != chk_word_s)) ||
                      (mac_valid_r && (prod_a_r != prod_b_r));
`else
   assign err_inc_s = out_valid_s && (pipe_out_s != chk_word_s);
`endif

   // Saturating error counter next value.
   always_comb begin
      err_nxt_s = err_cnt_r;
      if (start_ok_s) begin
         err_nxt_s = '0;
      end else if (err_inc_s && (err_cnt_r != ERR_MAX)) begin
         err_nxt_s = err_cnt_r + ERR_ONE;
      end else begin
         err_nxt_s = err_cnt_r;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_r <= '0;
      end else begin
         err_cnt_r <= err_nxt_s;
      end
   end

   // Test sequencer with registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 32'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         lock_lost_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start) begin
                  state_r     <= ST_LOCK_WAIT;
                  cnt_r       <= 32'd0;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
                  pass_r      <= 1'b0;
                  lock_lost_r <= 1'b0;
               end
            end
            ST_LOCK_WAIT: begin
               if (lock_sync_r) begin
                  state_r <= ST_SETTLE;
                  cnt_r   <= 32'd0;
               end
            end
            ST_SETTLE, ST_RUN, ST_DRAIN: begin
               if (!lock_sync_r) begin
                  state_r     <= ST_FAIL;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  pass_r      <= 1'b0;
                  lock_lost_r <= 1'b1;
               end else if ((state_r == ST_SETTLE) && (cnt_r == 32'(SETTLE_CYCLES - 1))) begin
                  state_r <= ST_RUN;
                  cnt_r   <= 32'd0;
               end else if ((state_r == ST_RUN) && (cnt_r == 32'(RUN_CYCLES - 1))) begin
                  state_r <= ST_DRAIN;
                  cnt_r   <= 32'd0;
               end else if ((state_r == ST_DRAIN) && (cnt_r == 32'(PIPE_STAGES - 1))) begin
                  // The last word is compared on this same edge, so use the next count.
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_nxt_s == '0);
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               pass_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign lock_lost = lock_lost_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_overclock_stress_checker.sv
// Directed self-checking bench for overclock_stress_checker.
module tb_overclock_stress_checker;

   logic       clk = 1'b0;
   logic       rst_n, pll_locked, start, inject_err;
   logic       busy, done, pass, lock_lost;
   logic [7:0] err_cnt;
   logic       pll_locked2, start2, inject_err2;
   logic       busy2, done2, pass2, lock_lost2;
   logic [7:0] err_cnt2;

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   always #5 clk = ~clk;

   overclock_stress_checker #(
      .DATA_W(24), .PIPE_STAGES(4), .SETTLE_CYCLES(16), .RUN_CYCLES(64), .ERR_W(8), .SEED(24'h000001)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .start(start), .inject_err(inject_err),
      .busy(busy), .done(done), .pass(pass), .lock_lost(lock_lost), .err_cnt(err_cnt)
   );

   overclock_stress_checker #(
      .DATA_W(24), .PIPE_STAGES(4), .SETTLE_CYCLES(16), .RUN_CYCLES(300), .ERR_W(8), .SEED(24'h000001)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked2), .start(start2), .inject_err(inject_err2),
      .busy(busy2), .done(done2), .pass(pass2), .lock_lost(lock_lost2), .err_cnt(err_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0; pll_locked = 1'b0; start = 1'b1; inject_err = 1'b0;
      pll_locked2 = 1'b1; start2 = 1'b0; inject_err2 = 1'b0;

      // Reset with start asserted: reset wins.
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_lock_lost", lock_lost, 1'b0);
      chk("rst_err_cnt", err_cnt, 8'd0);
      start = 1'b0; rst_n = 1'b1;
      tick();
      chk("rst_idle_busy", busy, 1'b0);

      // 1: unlocked PLL holds LOCK_WAIT.
      pulse_start();
      repeat (200) tick();
      chk("t1_busy", busy, 1'b1);
      chk("t1_done", done, 1'b0);
      pll_locked = 1'b1;
      wait_done(200, cyc);
      chk("t1_done_after_lock", done, 1'b1);
      chk("t1_pass", pass, 1'b1);

      // 2: clean run with lock already synchronised; latency 86 +/- 1.
      pulse_start();
      chk("t2_busy", busy, 1'b1);
      chk("t2_done_clr", done, 1'b0);
      wait_done(200, cyc);
      chk("t2_done", done, 1'b1);
      chk("t2_latency_ok", (cyc >= 85 && cyc <= 87), 1'b1);
      chk("t2_pass", pass, 1'b1);
      chk("t2_err_cnt", err_cnt, 8'd0);
      chk("t2_busy_end", busy, 1'b0);

      // 3: one injected error during RUN.
      pulse_start();
      repeat (30) tick();
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      wait_done(200, cyc);
      chk("t3_done", done, 1'b1);
      chk("t3_err_cnt", err_cnt, 8'd1);
      chk("t3_pass", pass, 1'b0);
      chk("t3_lock_lost", lock_lost, 1'b0);

      // 4: 300 corrupted words saturate an 8-bit counter.
      inject_err2 = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 500) begin
         tick();
         cyc++;
      end
      inject_err2 = 1'b0;
      chk("t4_done", done2, 1'b1);
      chk("t4_err_sat", err_cnt2, 8'd255);
      chk("t4_pass", pass2, 1'b0);

      // 5: lock lost mid RUN.
      pulse_start();
      repeat (40) tick();
      chk("t5_busy_run", busy, 1'b1);
      pll_locked = 1'b0;
      cyc = 0;
      while (!done && cyc < 6) begin
         tick();
         cyc++;
      end
      chk("t5_done", done, 1'b1);
      chk("t5_within_3", (cyc <= 3), 1'b1);
      chk("t5_lock_lost", lock_lost, 1'b1);
      chk("t5_pass", pass, 1'b0);
      chk("t5_busy", busy, 1'b0);
      pll_locked = 1'b1;
      repeat (3) tick();

      // 6: reset mid RUN after an error was counted, then a clean restart.
      pulse_start();
      repeat (30) tick();
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      repeat (10) tick();
      chk("t6_err_before_rst", err_cnt, 8'd1);
      rst_n = 1'b0;
      tick();
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_pass", pass, 1'b0);
      chk("t6_lock_lost", lock_lost, 1'b0);
      chk("t6_err_cnt", err_cnt, 8'd0);
      rst_n = 1'b1;
      tick();
      pulse_start();
      wait_done(200, cyc);
      chk("t6_restart_done", done, 1'b1);
      chk("t6_restart_pass", pass, 1'b1);
      chk("t6_restart_err", err_cnt, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
